// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction operands in, pipeline control and counters out.
// id_valid/issue: ID offers an instruction while id_valid is high; it is consumed on the
// rising edge where issue is high, otherwise the producer must hold it in ID unchanged.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int RFW    = 1,
  parameter int CW     = 4
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic [RFW-1:0]    id_rs1_rf;
  logic [RFW-1:0]    id_rs2_rf;
  logic [RFW-1:0]    id_rd_rf;
  logic              id_rs1_use;
  logic              id_rs2_use;
  logic              id_rd_we;
  logic              id_is_load;
  logic              id_is_div;
  logic              branch_redirect;
  logic              mem_stall;
  logic              pc_write_en;
  logic              ifid_write;
  logic              ifid_flush;
  logic              ctrl_flush;
  logic              issue;
  logic [1:0]        stall_type;
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_cycles;
  logic [CW-1:0]     dbg_div_cnt;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_rf, id_rs2_rf, id_rd_rf, id_rs1_use, id_rs2_use, id_rd_we,
           id_is_load, id_is_div, branch_redirect, mem_stall,
    input  pc_write_en, ifid_write, ifid_flush, ctrl_flush, issue, stall_type,
           stall_cycles, flush_cycles, dbg_div_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_rf, id_rs2_rf, id_rd_rf, id_rs1_use, id_rs2_use, id_rd_we,
           id_is_load, id_is_div, branch_redirect, mem_stall,
    output pc_write_en, ifid_write, ifid_flush, ctrl_flush, issue, stall_type,
           stall_cycles, flush_cycles, dbg_div_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-busy scoreboard for an in-order pipeline: per-register countdowns for
// multi-cycle producers, a divider busy counter, and stall/flush priority control.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int NUM_RF   = 2,
  parameter int LOAD_LAT = 1,
  parameter int DIV_LAT  = 8
) (
  input logic              clk,
  input logic              rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int RFW     = (NUM_RF > 1) ? $clog2(NUM_RF) : 1;
  localparam int MAX_LAT = (LOAD_LAT > DIV_LAT) ? LOAD_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int IW      = RFW + REG_AW;
  // Entry index is {rf, addr}; rf codes >= NUM_RF map to entries no legal op reaches.
  localparam int NENT    = 1 << IW;

  typedef logic [CW-1:0] cnt_t;

  cnt_t        cnt_q [NENT];
  cnt_t        cnt_d [NENT];
  cnt_t        div_cnt_q, div_cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  logic [IW-1:0] rs1_idx, rs2_idx, rd_idx;
  logic          rs1_busy, rs2_busy, rd_busy, div_busy, hazard;
  logic          pc_write_en, ifid_write, ifid_flush, ctrl_flush, issue;
  logic [1:0]    stall_type;

  assign rs1_idx = {bus.id_rs1_rf, bus.id_rs1_addr};
  assign rs2_idx = {bus.id_rs2_rf, bus.id_rs2_addr};
  assign rd_idx  = {bus.id_rd_rf, bus.id_rd_addr};

  assign rs1_busy = bus.id_rs1_use && (cnt_q[rs1_idx] != '0);
  assign rs2_busy = bus.id_rs2_use && (cnt_q[rs2_idx] != '0);
  assign rd_busy  = bus.id_rd_we && (cnt_q[rd_idx] != '0);
  assign div_busy = bus.id_is_div && (div_cnt_q != '0);
  assign hazard   = bus.id_valid && (rs1_busy || rs2_busy || rd_busy || div_busy);

  always_comb begin
    pc_write_en = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    ctrl_flush  = 1'b0;
    issue       = 1'b0;
    stall_type  = 2'd2;
    if (bus.mem_stall) begin
      stall_type = 2'd3;
    end else if (bus.branch_redirect) begin
      pc_write_en = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      ctrl_flush  = 1'b1;
      stall_type  = 2'd0;
    end else if (hazard) begin
      ctrl_flush = 1'b1;
      stall_type = 2'd1;
    end else begin
      pc_write_en = 1'b1;
      ifid_write  = 1'b1;
      issue       = bus.id_valid;
    end
  end

  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      cnt_d[i] = (bus.mem_stall || cnt_q[i] == '0) ? cnt_q[i] : cnt_q[i] - cnt_t'(1);
    end
    div_cnt_d = (bus.mem_stall || div_cnt_q == '0) ? div_cnt_q : div_cnt_q - cnt_t'(1);
    // A set wins over the same-edge decrement; integer x0 is hardwired and never tracked.
    if (issue && bus.id_rd_we && rd_idx != '0) begin
      if (bus.id_is_div) begin
        cnt_d[rd_idx] = cnt_t'(DIV_LAT);
      end else if (bus.id_is_load) begin
        cnt_d[rd_idx] = cnt_t'(LOAD_LAT);
      end
    end
    if (issue && bus.id_is_div) begin
      div_cnt_d = cnt_t'(DIV_LAT);
    end
    stall_cycles_d = stall_cycles_q;
    if (stall_type == 2'd1 && stall_cycles_q != 32'hFFFF_FFFF) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    flush_cycles_d = flush_cycles_q;
    if (stall_type == 2'd0 && flush_cycles_q != 32'hFFFF_FFFF) begin
      flush_cycles_d = flush_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) begin
        cnt_q[i] <= '0;
      end
      div_cnt_q      <= '0;
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      div_cnt_q      <= div_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign bus.pc_write_en  = pc_write_en;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.ctrl_flush   = ctrl_flush;
  assign bus.issue        = issue;
  assign bus.stall_type   = stall_type;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_cycles = flush_cycles_q;
  assign bus.dbg_div_cnt  = div_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios then random traffic, checked
// against a model that tracks the time at which each register becomes available.
module tb_hazard_scoreboard;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;
  localparam int DIV_LAT  = 8;
  localparam int CW       = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .RFW(1), .CW(CW)) bus ();

  hazard_scoreboard #(
    .REG_AW(REG_AW), .NUM_RF(2), .LOAD_LAT(LOAD_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: time advances only on edges without a memory freeze
  int          m_t;
  int          avail [64];
  int          div_avail;
  int unsigned m_stall;
  int unsigned m_flush;
  logic        last_issue;
  logic [1:0]  last_type;
  logic [6:0]  exp_q [$];

  function automatic int idx(input logic rf, input logic [4:0] a);
    return int'(rf) * 32 + int'(a);
  endfunction

  function automatic logic busy(input int i);
    return avail[i] > m_t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v,
                       input logic [4:0] a1, input logic f1, input logic u1,
                       input logic [4:0] a2, input logic f2, input logic u2,
                       input logic [4:0] ad, input logic fd, input logic we,
                       input logic ld, input logic dv);
    bus.id_valid    = v;
    bus.id_rs1_addr = a1;
    bus.id_rs1_rf   = f1;
    bus.id_rs1_use  = u1;
    bus.id_rs2_addr = a2;
    bus.id_rs2_rf   = f2;
    bus.id_rs2_use  = u2;
    bus.id_rd_addr  = ad;
    bus.id_rd_rf    = fd;
    bus.id_rd_we    = we;
    bus.id_is_load  = ld;
    bus.id_is_div   = dv;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // one clock: check outputs at negedge, advance the model at posedge
  task automatic cycle();
    logic       hz;
    logic [6:0] exp_ctl;
    logic [6:0] got_ctl;
    logic [6:0] want;
    int         s1, s2, d, dc;
    @(negedge clk);
    s1 = idx(bus.id_rs1_rf, bus.id_rs1_addr);
    s2 = idx(bus.id_rs2_rf, bus.id_rs2_addr);
    d  = idx(bus.id_rd_rf, bus.id_rd_addr);
    hz = bus.id_valid && ((bus.id_rs1_use && busy(s1)) || (bus.id_rs2_use && busy(s2)) ||
                          (bus.id_rd_we && busy(d)) || (bus.id_is_div && div_avail > m_t));
    if (bus.mem_stall)            exp_ctl = 7'b0000011;
    else if (bus.branch_redirect) exp_ctl = 7'b1111000;
    else if (hz)                  exp_ctl = 7'b0001001;
    else                          exp_ctl = {4'b1100, bus.id_valid, 2'b10};
    exp_q.push_back(exp_ctl);
    got_ctl = {bus.pc_write_en, bus.ifid_write, bus.ifid_flush, bus.ctrl_flush,
               bus.issue, bus.stall_type};
    want = exp_q.pop_front();
    chk("ctl", 32'(got_ctl), 32'(want));
    chk("stall_cycles", bus.stall_cycles, m_stall);
    chk("flush_cycles", bus.flush_cycles, m_flush);
    dc = div_avail - m_t;
    if (dc < 0) dc = 0;
    chk("div_cnt", 32'(bus.dbg_div_cnt), 32'(dc));
    last_issue = bus.issue;
    last_type  = bus.stall_type;
    @(posedge clk);
    if (!rst_n) begin
      foreach (avail[i]) avail[i] = 0;
      div_avail = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else if (!bus.mem_stall) begin
      if (exp_ctl[1:0] == 2'd1 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (exp_ctl[1:0] == 2'd0 && m_flush != 32'hFFFF_FFFF) m_flush++;
      if (exp_ctl[2] && bus.id_rd_we && d != 0) begin
        if (bus.id_is_div)       avail[d] = m_t + DIV_LAT + 1;
        else if (bus.id_is_load) avail[d] = m_t + LOAD_LAT + 1;
      end
      if (exp_ctl[2] && bus.id_is_div) div_avail = m_t + DIV_LAT + 1;
      m_t++;
    end
    #1;
  endtask

  task automatic run_until_issue(input int max_cyc, output int hz_cnt);
    bit done;
    hz_cnt = 0;
    done   = 0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      cycle();
      if (last_issue) done = 1;
      else if (last_type == 2'd1) hz_cnt++;
    end
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int h;
    total = 0;
    bad   = 0;
    m_t   = 0;
    div_avail = 0;
    m_stall = 0;
    m_flush = 0;
    foreach (avail[i]) avail[i] = 0;
    bus.branch_redirect = 0;
    bus.mem_stall       = 0;
    idle();
    rst_n = 0;
    #1;
    cycle();
    cycle();
    rst_n = 1;
    chk("rst_stall_cnt", bus.stall_cycles, 0);
    chk("rst_flush_cnt", bus.flush_cycles, 0);
    chk("rst_div_cnt", 32'(bus.dbg_div_cnt), 0);

    // load x5 then use x5: one stall cycle
    drive(1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0);
    cycle();
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_until_issue(20, h);
    chk("load_use_stalls", h, 1);
    chk("load_use_stall_cnt", bus.stall_cycles, 1);

    // divide into f3 then use f3: DIV_LAT stalls
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1);
    cycle();
    drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_until_issue(40, h);
    chk("div_use_stalls", h, DIV_LAT);

    // divide into f3 then read x3: different file, no stall
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1);
    cycle();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_until_issue(20, h);
    chk("x3_no_stall", h, 0);
    idle();
    for (int i = 0; i < 10; i++) cycle();

    // load to x0 is never tracked
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle();
    drive(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    run_until_issue(20, h);
    chk("x0_no_stall", h, 0);

    // pending stall coincides with a redirect: flush wins, nothing set
    drive(1, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 0);
    cycle();
    drive(1, 9, 0, 1, 0, 0, 0, 10, 0, 1, 1, 0);
    bus.branch_redirect = 1;
    cycle();
    bus.branch_redirect = 0;
    chk("br_type", 32'(last_type), 0);
    chk("br_issue", 32'(last_issue), 0);
    chk("br_flush_cnt", bus.flush_cycles, 1);
    drive(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_until_issue(20, h);
    chk("br_no_set", h, 0);

    // memory freeze holds the divider count
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("div_cnt_5", 32'(bus.dbg_div_cnt), 5);
    bus.mem_stall = 1;
    for (int i = 0; i < 3; i++) cycle();
    bus.mem_stall = 0;
    chk("div_cnt_frozen", 32'(bus.dbg_div_cnt), 5);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_until_issue(20, h);
    chk("div_struct_stalls", h, 5);
    idle();
    for (int i = 0; i < 10; i++) cycle();

    // reset mid-countdown: div_cnt = 4 and x7 busy
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 0);
    cycle();
    chk("pre_rst_div_cnt", 32'(bus.dbg_div_cnt), 4);
    idle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("post_rst_div_cnt", 32'(bus.dbg_div_cnt), 0);
    chk("post_rst_stall_cnt", bus.stall_cycles, 0);
    chk("post_rst_flush_cnt", bus.flush_cycles, 0);
    drive(1, 7, 0, 1, 0, 0, 0, 7, 0, 1, 0, 1);
    run_until_issue(20, h);
    chk("post_rst_no_stall", h, 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic ld, dv;
      int   k;
      k  = $urandom_range(0, 3);
      ld = (k == 1);
      dv = (k == 2);
      drive(logic'($urandom_range(0, 9) < 8),
            5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
            ld, dv);
      bus.branch_redirect = ($urandom_range(0, 9) == 0);
      bus.mem_stall       = ($urandom_range(0, 9) == 0);
      rst_n               = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1;
    bus.branch_redirect = 0;
    bus.mem_stall = 0;
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
